// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: double-flop input synchroniser, mid-bit sampling,
// LSB-first data with optional parity and one or two stop bits, valid/ready output.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 10417,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 clr_err_i,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLK_PER_BIT - 32'd1) / 32'd2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 32'd1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 32'd1);
  localparam bit               PAR_EN    = (PARITY != 32'd0);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  // Mismatch between data word plus received parity bit and the selected mode.
  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic p);
    logic odd_ones;
    odd_ones = (^d) ^ p;
    if (PARITY == 32'd1) begin
      return odd_ones;
    end else if (PARITY == 32'd2) begin
      return ~odd_ones;
    end else begin
      return 1'b0;
    end
  endfunction

  logic                 rx_meta_q;
  logic                 rx_sync_q;
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_out_q;
  logic                 ferr_out_q;
  logic                 overrun_q;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame FSM: the bit counter restarts at every sample point, so it never wraps.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT_IDLE: begin
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          cnt_q  <= '0;
          idx_q  <= '0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
          if (!rx_sync_q) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync_q;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            perr_q  <= parity_err_f(shift_q, rx_sync_q);
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (!rx_sync_q) begin
              ferr_q <= 1'b1;
            end
            // idx is reused as the stop-bit index here
            if (idx_q == STOP_LAST) begin
              idx_q   <= '0;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= ferr_q ? S_WAIT_IDLE : S_IDLE;
        end
        default: begin
          state_q <= S_WAIT_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Output stage: holds a word until accepted; a word arriving while one is held is dropped.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if ((state_q == S_DONE) && (!valid_q || ready_i)) begin
        data_q     <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_q;
        valid_q    <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      if ((state_q == S_DONE) && valid_q && !ready_i) begin
        overrun_q <= 1'b1;
      end else if (clr_err_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized bench for uart_rx_param: four instances (8N1, 8E1, 8O1, 7N2)
// checked against a frame-level reference model and word queues.
module tb_uart_rx_param;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_a, rx_p, rx_b;
  logic       rdy_a, rdy_p, rdy_b, clr_a;
  logic [7:0] d_a, d_e, d_o;
  logic [6:0] d_b;
  logic       v_a, v_e, v_o, v_b;
  logic       pe_a, pe_e, pe_o, pe_b;
  logic       fe_a, fe_e, fe_o, fe_b;
  logic       ov_a, ov_e, ov_o, ov_b;
  logic       bz_a, bz_e, bz_o, bz_b;

  int checks = 0;
  int errors = 0;

  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_ni(rst_n), .rx_i(rx_a), .data_o(d_a), .valid_o(v_a), .ready_i(rdy_a),
    .parity_err_o(pe_a), .frame_err_o(fe_a), .overrun_o(ov_a), .clr_err_i(clr_a), .busy_o(bz_a));
  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_ni(rst_n), .rx_i(rx_p), .data_o(d_e), .valid_o(v_e), .ready_i(rdy_p),
    .parity_err_o(pe_e), .frame_err_o(fe_e), .overrun_o(ov_e), .clr_err_i(1'b0), .busy_o(bz_e));
  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_ni(rst_n), .rx_i(rx_p), .data_o(d_o), .valid_o(v_o), .ready_i(rdy_p),
    .parity_err_o(pe_o), .frame_err_o(fe_o), .overrun_o(ov_o), .clr_err_i(1'b0), .busy_o(bz_o));
  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_ni(rst_n), .rx_i(rx_b), .data_o(d_b), .valid_o(v_b), .ready_i(rdy_b),
    .parity_err_o(pe_b), .frame_err_o(fe_b), .overrun_o(ov_b), .clr_err_i(1'b0), .busy_o(bz_b));

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  word_t q_a[$], q_e[$], q_o[$], q_b[$];

  // Record every accepted word (valid && ready at a rising edge).
  always @(posedge clk) begin
    if (v_a && rdy_a) q_a.push_back(word_t'({1'b0, d_a, pe_a, fe_a}));
    if (v_e && rdy_p) q_e.push_back(word_t'({1'b0, d_e, pe_e, fe_e}));
    if (v_o && rdy_p) q_o.push_back(word_t'({1'b0, d_o, pe_o, fe_o}));
    if (v_b && rdy_b) q_b.push_back(word_t'({2'b00, d_b, pe_b, fe_b}));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int line, input logic v);
    case (line)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_b = v;
    endcase
  endtask

  task automatic bit_time(input int line, input logic v);
    drive(line, v);
    cycles(CPB);
  endtask

  // One frame: start, LSB-first data, optional parity bit (pbit < 0 means none), stop bits.
  task automatic send(input int line, input logic [8:0] d, input int nbits, input int pbit,
                      input int nstop);
    bit_time(line, 1'b0);
    for (int i = 0; i < nbits; i++) bit_time(line, d[i]);
    if (pbit >= 0) bit_time(line, pbit[0]);
    for (int i = 0; i < nstop; i++) bit_time(line, 1'b1);
    cycles(4);
  endtask

  // Reference: received word is the low nbits; parity error from the total count of ones.
  function automatic logic [8:0] model_data(input logic [8:0] d, input int nbits);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = d[i];
    return r;
  endfunction

  function automatic logic model_perr(input int mode, input logic [8:0] d, input int nbits,
                                      input int pbit);
    int ones;
    ones = pbit;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    if (mode == 1) return (ones % 2) == 1;
    if (mode == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // Exactly one word expected from instance inst since the last call.
  task automatic expect_word(input string tag, input int inst, input logic [8:0] d,
                             input logic pe, input logic fe);
    word_t w;
    int    n;
    w = '0;
    case (inst)
      0:       begin n = q_a.size(); if (n > 0) w = q_a.pop_front(); q_a.delete(); end
      1:       begin n = q_e.size(); if (n > 0) w = q_e.pop_front(); q_e.delete(); end
      2:       begin n = q_o.size(); if (n > 0) w = q_o.pop_front(); q_o.delete(); end
      default: begin n = q_b.size(); if (n > 0) w = q_b.pop_front(); q_b.delete(); end
    endcase
    chk({tag, " count"}, n, 1);
    if (n > 0) begin
      chk({tag, " data"}, w.d, d);
      chk({tag, " perr"}, w.pe, pe);
      chk({tag, " ferr"}, w.fe, fe);
    end
  endtask

  initial begin
    logic [8:0] d;
    int         pb;

    rst_n = 1'b0;
    rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b1; rdy_p = 1'b1; rdy_b = 1'b1; clr_a = 1'b0;
    cycles(3);
    chk("rst data", d_a, 0);
    chk("rst valid", v_a, 0);
    chk("rst perr", pe_a, 0);
    chk("rst ferr", fe_a, 0);
    chk("rst ovr", ov_a, 0);
    chk("rst 7n2 valid", v_b, 0);
    rst_n = 1'b1;
    cycles(6);
    chk("idle busy e", bz_e, 0);
    chk("idle busy o", bz_o, 0);
    chk("idle busy b", bz_b, 0);

    send(0, 9'h0A5, 8, -1, 1);
    expect_word("8n1 a5", 0, 9'h0A5, 1'b0, 1'b0);
    chk("8n1 a5 ovr", ov_a, 0);
    chk("8n1 a5 valid drop", v_a, 0);

    for (int p = 1; p >= 0; p--) begin
      send(1, 9'h003, 8, p, 1);
      expect_word("even 03", 1, 9'h003, model_perr(1, 9'h003, 8, p), 1'b0);
      expect_word("odd 03", 2, 9'h003, model_perr(2, 9'h003, 8, p), 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      d = 9'($urandom_range(0, 255));
      send(0, d, 8, -1, 1);
      expect_word("rand 8n1", 0, model_data(d, 8), 1'b0, 1'b0);
      pb = int'($urandom_range(0, 1));
      d = 9'($urandom_range(0, 255));
      send(1, d, 8, pb, 1);
      expect_word("rand even", 1, model_data(d, 8), model_perr(1, d, 8, pb), 1'b0);
      expect_word("rand odd", 2, model_data(d, 8), model_perr(2, d, 8, pb), 1'b0);
    end
    chk("par ovr e", ov_e, 0);
    chk("par ovr o", ov_o, 0);

    drive(0, 1'b0);
    cycles(5);
    drive(0, 1'b1);
    cycles(3);
    chk("glitch busy in start", bz_a, 1);
    cycles(30);
    chk("glitch busy back", bz_a, 0);
    chk("glitch no word", q_a.size(), 0);
    chk("glitch valid", v_a, 0);

    drive(0, 1'b0);
    cycles(20 * CPB);
    expect_word("break", 0, 9'h000, 1'b0, 1'b1);
    chk("break still busy", bz_a, 1);
    drive(0, 1'b1);
    cycles(CPB);
    send(0, 9'h03C, 8, -1, 1);
    expect_word("after break", 0, 9'h03C, 1'b0, 1'b0);

    rdy_a = 1'b0;
    send(0, 9'h011, 8, -1, 1);
    chk("ovr first valid", v_a, 1);
    chk("ovr first data", d_a, 8'h11);
    chk("ovr first flag", ov_a, 0);
    send(0, 9'h022, 8, -1, 1);
    chk("ovr hold data", d_a, 8'h11);
    chk("ovr hold valid", v_a, 1);
    chk("ovr set", ov_a, 1);
    clr_a = 1'b1;
    cycles(1);
    clr_a = 1'b0;
    chk("ovr cleared", ov_a, 0);
    chk("ovr valid kept", v_a, 1);
    rdy_a = 1'b1;
    cycles(1);
    chk("ovr valid drop", v_a, 0);
    expect_word("ovr drain", 0, 9'h011, 1'b0, 1'b0);

    send(2, 9'h02B, 7, -1, 1);
    bit_time(2, 1'b0);
    drive(2, 1'b1);
    cycles(2 * CPB);
    expect_word("7n2 stop2 low", 3, 9'h02B, 1'b0, 1'b1);

    rdy_a = 1'b0;
    send(0, 9'h066, 8, -1, 1);
    chk("pre-rst valid", v_a, 1);
    bit_time(2, 1'b0);
    for (int i = 0; i < 3; i++) bit_time(2, 1'b1);
    drive(2, 1'b0);
    cycles(8);
    rst_n = 1'b0;
    cycles(2);
    chk("mid rst data a", d_a, 0);
    chk("mid rst valid a", v_a, 0);
    chk("mid rst data b", d_b, 0);
    chk("mid rst valid b", v_b, 0);
    chk("mid rst perr b", pe_b, 0);
    chk("mid rst ferr b", fe_b, 0);
    chk("mid rst ovr b", ov_b, 0);
    drive(2, 1'b1);
    rdy_a = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(CPB);
    send(2, 9'h05A, 7, -1, 2);
    expect_word("7n2 5a", 3, 9'h05A, 1'b0, 1'b0);
    chk("7n2 ovr", ov_b, 0);
    chk("no stray word a", q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
